keypad_scanner: RTL and testbench

Matrix-keypad front end for the calculator datapath:
- Scans a 4x4 active-low keypad and synchronizes and debounces the row lines.
- Emits exactly one single-cycle `key_valid` strobe per physical press, with a 4-bit key code and decoded class flags.
- It is the producer side of the key-entry handshake. The number-entry and operand-entry FSMs consume `key_valid` and the class flags to build operands, latch operators and trigger the result.

---
 rtl/keypad_scanner.sv | 243 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Front end for a 4x4 active-low matrix keypad. It drives one column low at a
// time, samples the synchronized row lines once per scan tick, debounces the
// press and the release, and then emits one single-cycle key_valid strobe per
// physical press. The strobe carries a 4-bit key code and decoded class flags.
//
// Handshake: key_valid is a one-cycle, fire-and-forget strobe with no ready
// input. The consumer must sample key_code and the class flags on the cycle
// key_valid is high. Those outputs are then held until the next accept, so a
// consumer that reads them later still sees the last accepted key.
//
// Parameters
//   SCAN_DIV       clock cycles per scan tick (column dwell), >= 4
//   DEBOUNCE_TICKS consecutive stable ticks needed for press and release, >= 1
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   row_n[3:0] in   keypad rows, active-low, asynchronous to clk
//   col_n[3:0] out  column drive, one-hot active-low
//   key_valid  out  one-cycle strobe: new key accepted
//   key_code   out  code of the last accepted key
//   is_digit   out  key_code is 0..9
//   is_op      out  key_code is 0xA..0xD
//   is_equal   out  key_code is 0xF
//   is_clear   out  key_code is 0xE
//   key_down   out  high while a press is being debounced, emitted or released
// -----------------------------------------------------------------------------
module keypad_scanner #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_TICKS = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       is_digit,
   output logic       is_op,
   output logic       is_equal,
   output logic       is_clear,
   output logic       key_down
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DT_LAST  = CW'(DEBOUNCE_TICKS);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_EMIT     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_e;

   // State register is kept as a named enum so it can be observed and
   // bound to directly.
   state_e          state_q;

   logic [3:0]      row_meta_q;
   logic [3:0]      row_sync_q;
   logic [DW-1:0]   div_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      col_idx_q;
   logic [3:0]      col_n_q;
   logic [1:0]      row_idx_q;
   logic            key_valid_q;
   logic [3:0]      key_code_q;
   logic            is_digit_q;
   logic            is_op_q;
   logic            is_equal_q;
   logic            is_clear_q;
   logic            key_down_q;

   logic            tick;
   logic            any_low;
   logic [1:0]      low_row;
   logic            latched_low;
   logic [CW-1:0]   cnt_inc;
   logic            accept;
   logic [3:0]      map_code;

   // Code of the key at the given row and column.
   function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      code = 4'h0;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         4'b11_11: code = 4'hD;
         default:  code = 4'h0;
      endcase
      return code;
   endfunction

   // Two-flop synchronizer. It resets to "all released" so that a key held
   // through reset is seen as a fresh press afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
      end else begin
         row_meta_q <= row_n;
         row_sync_q <= row_meta_q;
      end
   end

   assign tick    = (div_q == DIV_LAST);
   assign any_low = ~&row_sync_q;
   assign cnt_inc = cnt_q + 1'b1;

   // When several rows are low in the column, the lowest row index wins.
   always_comb begin
      low_row = 2'd3;
      if (!row_sync_q[0])      low_row = 2'd0;
      else if (!row_sync_q[1]) low_row = 2'd1;
      else if (!row_sync_q[2]) low_row = 2'd2;
      else                     low_row = 2'd3;
   end

   assign latched_low = ~row_sync_q[row_idx_q];
   assign map_code    = map_key(row_idx_q, col_idx_q);

   // The press is accepted on the tick that brings the stable count to
   // DEBOUNCE_TICKS. The first term only matters when DEBOUNCE_TICKS is 1:
   // the detecting tick already counts as one stable sample, so the accept
   // happens on the very next cycle.
   assign accept = (state_q == ST_DEBOUNCE) &&
                   ((cnt_q >= DT_LAST) || (tick && latched_low && (cnt_inc == DT_LAST)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_SCAN;
         div_q       <= '0;
         cnt_q       <= '0;
         col_idx_q   <= 2'd0;
         col_n_q     <= 4'b1110;
         row_idx_q   <= 2'd0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         is_digit_q  <= 1'b0;
         is_op_q     <= 1'b0;
         is_equal_q  <= 1'b0;
         is_clear_q  <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         div_q       <= tick ? '0 : div_q + 1'b1;
         key_valid_q <= 1'b0;

         case (state_q)
            ST_SCAN: begin
               if (tick) begin
                  if (any_low) begin
                     // Hold the current column and lock onto one row.
                     row_idx_q  <= low_row;
                     cnt_q      <= CW'(1);
                     key_down_q <= 1'b1;
                     state_q    <= ST_DEBOUNCE;
                  end else begin
                     col_idx_q <= col_idx_q + 2'd1;
                     col_n_q   <= {col_n_q[2:0], col_n_q[3]};
                  end
               end
            end

            ST_DEBOUNCE: begin
               if (accept) begin
                  key_valid_q <= 1'b1;
                  key_code_q  <= map_code;
                  is_digit_q  <= (map_code <= 4'h9);
                  is_op_q     <= (map_code >= 4'hA) && (map_code <= 4'hD);
                  is_equal_q  <= (map_code == 4'hF);
                  is_clear_q  <= (map_code == 4'hE);
                  state_q     <= ST_EMIT;
               end else if (tick) begin
                  if (latched_low) begin
                     cnt_q <= cnt_inc;
                  end else begin
                     // Bounce: abandon this press and move on to the next column.
                     cnt_q      <= '0;
                     col_idx_q  <= col_idx_q + 2'd1;
                     col_n_q    <= {col_n_q[2:0], col_n_q[3]};
                     key_down_q <= 1'b0;
                     state_q    <= ST_SCAN;
                  end
               end
            end

            ST_EMIT: begin
               cnt_q   <= '0;
               state_q <= ST_RELEASE;
            end

            ST_RELEASE: begin
               if (tick) begin
                  if (latched_low) begin
                     cnt_q <= '0;
                  end else if (cnt_inc == DT_LAST) begin
                     cnt_q      <= '0;
                     col_idx_q  <= col_idx_q + 2'd1;
                     col_n_q    <= {col_n_q[2:0], col_n_q[3]};
                     key_down_q <= 1'b0;
                     state_q    <= ST_SCAN;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end

            default: begin
               state_q <= ST_SCAN;
            end
         endcase
      end
   end

   assign col_n     = col_n_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign is_digit  = is_digit_q;
   assign is_op     = is_op_q;
   assign is_equal  = is_equal_q;
   assign is_clear  = is_clear_q;
   assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_TICKS=3. A small
// keypad model turns a 16-bit pressed-key mask plus the DUT's column drive
// into row levels. Each scenario pushes the key codes it expects into exp_q.
// A monitor pops one code per key_valid strobe and checks the code, the flags
// and the strobe width.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        is_digit;
   logic        is_op;
   logic        is_equal;
   logic        is_clear;
   logic        key_down;

   // Bit r*4+c set means the key at row r / column c is held down.
   logic [15:0] key_mask = '0;

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          pulse_cnt    = 0;
   logic        prev_kv      = 1'b0;
   logic [3:0]  exp_q[$];

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_TICKS (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_valid (key_valid),
      .key_code  (key_code),
      .is_digit  (is_digit),
      .is_op     (is_op),
      .is_equal  (is_equal),
      .is_clear  (is_clear),
      .key_down  (key_down)
   );

   // Clock and reset.
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end

   // Keypad model: a row is pulled low when a held key sits on the driven column.
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         row_n[r] = ~|(key_mask[r*4 +: 4] & ~col_n);
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      logic [3:0] exp_code;
      logic [3:0] exp_flags;
      if (key_valid === 1'b1) begin
         pulse_cnt++;
         tests_run++;
         if (prev_kv === 1'b1) begin
            tests_failed++;
            $display("FAIL strobe_width: key_valid high 2 cycles in a row, required 1");
         end
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_strobe: key_code=%h, no strobe expected", key_code);
         end else begin
            exp_code  = exp_q.pop_front();
            exp_flags = {(exp_code <= 4'h9), (exp_code >= 4'hA && exp_code <= 4'hD),
                         (exp_code == 4'hF), (exp_code == 4'hE)};
            tests_run++;
            if (key_code !== exp_code) begin
               tests_failed++;
               $display("FAIL strobe_code: got %h, required %h", key_code, exp_code);
            end
            tests_run++;
            if ({is_digit, is_op, is_equal, is_clear} !== exp_flags) begin
               tests_failed++;
               $display("FAIL strobe_flags: got %b, required %b (digit,op,equal,clear)",
                        {is_digit, is_op, is_equal, is_clear}, exp_flags);
            end
         end
      end
      prev_kv = key_valid;
   end

   // Driver helpers: all stimulus changes happen 1 time unit after a negedge.
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_pulse(input int target, input int budget, input string name);
      int i;
      i = 0;
      while (pulse_cnt < target && i < budget) begin
         step(1);
         i++;
      end
      tests_run++;
      if (pulse_cnt < target) begin
         tests_failed++;
         $display("FAIL %s: no strobe within %0d cycles (strobes=%0d, required %0d)",
                  name, budget, pulse_cnt, target);
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_cols[4];
      logic [3:0] prev;
      int         i;
      exp_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      reset    = 1'b1;
      key_mask = '0;
      step(3);
      tests_run++;
      if (col_n !== 4'b1110) begin
         tests_failed++; $display("FAIL reset_col: got %b, required 1110", col_n);
      end
      tests_run++;
      if (key_valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_valid: got %b, required 0", key_valid);
      end
      tests_run++;
      if (key_code !== 4'h0) begin
         tests_failed++; $display("FAIL reset_code: got %h, required 0", key_code);
      end
      tests_run++;
      if ({is_digit, is_op, is_equal, is_clear} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b, required 0000", {is_digit, is_op, is_equal, is_clear});
      end
      tests_run++;
      if (key_down !== 1'b0) begin
         tests_failed++; $display("FAIL reset_key_down: got %b, required 0", key_down);
      end
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         prev = col_n;
         i    = 0;
         while (col_n === prev && i < 12) begin
            step(1);
            i++;
         end
         tests_run++;
         if (col_n !== exp_cols[k]) begin
            tests_failed++;
            $display("FAIL rotate_col%0d: got %b, required %b", k, col_n, exp_cols[k]);
         end
         tests_run++;
         if (i !== 4) begin
            tests_failed++;
            $display("FAIL rotate_interval%0d: got %0d cycles, required 4", k, i);
         end
      end
   endtask

   task automatic test_clean_press();
      int base;
      int kd_bad;
      base   = pulse_cnt;
      kd_bad = 0;
      exp_q.push_back(4'h6);
      key_mask[1*4+2] = 1'b1;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (pulse_cnt > base && key_down !== 1'b1) kd_bad++;
      end
      tests_run++;
      if (pulse_cnt <= base) begin
         tests_failed++; $display("FAIL clean_pulse: no strobe during 200-cycle hold");
      end
      tests_run++;
      if (kd_bad !== 0) begin
         tests_failed++;
         $display("FAIL clean_key_down: key_down low for %0d held cycles, required 0", kd_bad);
      end
      key_mask = '0;
      step(40);
      tests_run++;
      if (pulse_cnt !== base + 1) begin
         tests_failed++;
         $display("FAIL clean_count: got %0d strobes, required 1", pulse_cnt - base);
      end
      tests_run++;
      if (key_code !== 4'h6 || is_digit !== 1'b1) begin
         tests_failed++;
         $display("FAIL clean_hold: code=%h digit=%b, required 6 and 1", key_code, is_digit);
      end
      tests_run++;
      if (key_down !== 1'b0) begin
         tests_failed++; $display("FAIL clean_release: key_down=%b, required 0", key_down);
      end
   endtask

   task automatic test_press_bounce();
      int base;
      base = pulse_cnt;
      exp_q.push_back(4'hA);
      for (int i = 0; i < 2; i++) begin
         key_mask[0*4+3] = 1'b1;
         step(4);
         key_mask[0*4+3] = 1'b0;
         step(4);
      end
      key_mask[0*4+3] = 1'b1;
      wait_pulse(base + 1, 80, "bounce_pulse");
      step(20);
      key_mask = '0;
      step(40);
      tests_run++;
      if (pulse_cnt !== base + 1) begin
         tests_failed++;
         $display("FAIL bounce_count: got %0d strobes, required 1", pulse_cnt - base);
      end
      tests_run++;
      if (key_code !== 4'hA || is_op !== 1'b1) begin
         tests_failed++;
         $display("FAIL bounce_hold: code=%h op=%b, required a and 1", key_code, is_op);
      end
   endtask

   task automatic test_release_bounce();
      int base;
      base = pulse_cnt;
      exp_q.push_back(4'h8);
      key_mask[2*4+1] = 1'b1;
      wait_pulse(base + 1, 80, "relbounce_first");
      step(20);
      key_mask = '0;
      step(4);
      key_mask[2*4+1] = 1'b1;
      step(8);
      key_mask = '0;
      step(40);
      tests_run++;
      if (pulse_cnt !== base + 1) begin
         tests_failed++;
         $display("FAIL relbounce_extra: got %0d strobes, required 1", pulse_cnt - base);
      end
      tests_run++;
      if (key_down !== 1'b0) begin
         tests_failed++; $display("FAIL relbounce_key_down: got %b, required 0", key_down);
      end
      exp_q.push_back(4'hF);
      key_mask[3*4+2] = 1'b1;
      wait_pulse(base + 2, 80, "relbounce_next");
      step(10);
      key_mask = '0;
      step(40);
      tests_run++;
      if (key_code !== 4'hF || is_equal !== 1'b1) begin
         tests_failed++;
         $display("FAIL relbounce_equal: code=%h equal=%b, required f and 1", key_code, is_equal);
      end
      tests_run++;
      if (pulse_cnt !== base + 2) begin
         tests_failed++;
         $display("FAIL relbounce_count: got %0d strobes, required 2", pulse_cnt - base);
      end
   endtask

   task automatic test_multi_key();
      int base;
      base = pulse_cnt;
      exp_q.push_back(4'h1);
      key_mask[0*4+0] = 1'b1;
      key_mask[2*4+0] = 1'b1;
      wait_pulse(base + 1, 80, "multi_first");
      key_mask[1*4+3] = 1'b1;
      step(60);
      tests_run++;
      if (pulse_cnt !== base + 1) begin
         tests_failed++;
         $display("FAIL multi_blocked: got %0d strobes while held, required 1", pulse_cnt - base);
      end
      exp_q.push_back(4'hB);
      key_mask[0*4+0] = 1'b0;
      key_mask[2*4+0] = 1'b0;
      wait_pulse(base + 2, 80, "multi_second");
      tests_run++;
      if (key_code !== 4'hB || is_op !== 1'b1) begin
         tests_failed++;
         $display("FAIL multi_second_code: code=%h op=%b, required b and 1", key_code, is_op);
      end
      key_mask = '0;
      step(40);
   endtask

   task automatic test_reset_mid();
      int base;
      int i;
      base = pulse_cnt;
      key_mask[0*4+2] = 1'b1;
      i = 0;
      while (key_down !== 1'b1 && i < 80) begin
         step(1);
         i++;
      end
      tests_run++;
      if (key_down !== 1'b1) begin
         tests_failed++; $display("FAIL midreset_detect: key_down never rose, required 1");
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (col_n !== 4'b1110) begin
         tests_failed++; $display("FAIL midreset_col: got %b, required 1110", col_n);
      end
      tests_run++;
      if (key_down !== 1'b0 || key_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: key_down=%b key_valid=%b, required 0 0", key_down, key_valid);
      end
      tests_run++;
      if (key_code !== 4'h0) begin
         tests_failed++; $display("FAIL midreset_code: got %h, required 0", key_code);
      end
      step(3);
      reset = 1'b0;
      exp_q.push_back(4'h3);
      i = 0;
      while (pulse_cnt == base && i < 80) begin
         step(1);
         i++;
      end
      tests_run++;
      if (pulse_cnt == base) begin
         tests_failed++; $display("FAIL midreset_repress: no strobe within 80 cycles");
      end
      tests_run++;
      if (i < 12) begin
         tests_failed++;
         $display("FAIL midreset_latency: strobe %0d cycles after reset, required >= 12", i);
      end
      key_mask = '0;
      step(40);
      tests_run++;
      if (pulse_cnt !== base + 1) begin
         tests_failed++;
         $display("FAIL midreset_count: got %0d strobes, required 1", pulse_cnt - base);
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_press_bounce();
      test_release_bounce();
      test_multi_key();
      test_reset_mid();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d expected strobes never seen, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
